sdram_rr_arb: RTL and testbench
===============================

SDRAM_RR_ARB -- requirements
Module: sdram_rr_arb

Interface
REQ-001 NUM_CH, 2, number of requesting channels (1..4).
REQ-002 ADDR_W, 20, SDRAM word-address width.
REQ-003 REGION_W, 18, per-channel region offset width; channel i base = i << REGION_W; requires REGION_W + clog2(NUM_CH) <= ADDR_W.
REQ-004 BURST_LEN, 256, words per burst; offset step; power of two, < 2^REGION_W.
REQ-005 TIMEOUT_CYC, 1023, watchdog limit in cycles (used only with SDRAM_ARB_TIMEOUT_EN).
REQ-006 S_CLK  input  1  single system clock; all logic on rising edge.
REQ-007 RST_N  input  1  reset, asynchronous, active-low.
REQ-008 ch_req  input  NUM_CH  per-channel burst request, level.
REQ-009 ch_dir  input  NUM_CH  per-channel direction: 1 = write, 0 = read.
REQ-010 ch_clr  input  NUM_CH  per-channel offset clear (frame restart), one-cycle pulse.
REQ-011 ch_done  output  NUM_CH  one-cycle pulse when the channel's burst is acknowledged.
REQ-012 sdram_addr  output  ADDR_W  burst start address to the SDRAM top.
REQ-013 write_req / read_req  output  1 each  burst request to the SDRAM top.
REQ-014 write_ack / read_ack  input  1 each  burst acknowledge from the SDRAM top.
REQ-015 err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-016 FSM states: IDLE, REQ, DONE; registered outputs only.
REQ-017 IDLE: if any ch_req bit is set, winner = first set bit searching from rr_ptr upward modulo NUM_CH; latch sel, dir and address; go to REQ next edge.
REQ-018 REQ: write_req = dir, read_req = ~dir, sdram_addr = (sel << REGION_W) + offset[sel]; held stable until the matching ack is sampled high.
REQ-019 Latency: ch_req sampled high in IDLE at edge N -> write_req/read_req high after edge N.
REQ-020 In REQ, the non-matching ack is ignored; ch_req deasserting does not cancel the burst.
REQ-021 On matching ack: go to DONE; in DONE, write_req = read_req = 0, ch_done[sel] pulses for one cycle, offset[sel] += BURST_LEN modulo 2^REGION_W, rr_ptr = sel + 1 modulo NUM_CH; return to IDLE.
REQ-022 Minimum one IDLE cycle between bursts; never both write_req and read_req high.
REQ-023 Offset wraps from 2^REGION_W - BURST_LEN to 0 with no flag.
REQ-024 ch_clr[i] sets offset[i] = 0 on any cycle; if coincident with the DONE increment of the same channel, the clear wins (offset = 0).
REQ-025 ch_clr during REQ of the same channel does not alter the sdram_addr already presented.
REQ-026 Single-channel config (NUM_CH = 1): rr_ptr is constant 0.

Reset
REQ-027 RST_N low asynchronously forces: state IDLE, write_req = read_req = 0, ch_done = 0, err = 0, sdram_addr = 0, all offsets = 0, rr_ptr = 0, watchdog = 0.
REQ-028 Reset mid-burst abandons the burst; no ch_done is issued.

Configuration
REQ-029 Macro SDRAM_ARB_TIMEOUT_EN defined: watchdog counts cycles in REQ; on reaching TIMEOUT_CYC without the matching ack -> drop the request, pulse err for one cycle, leave the offset unchanged, advance rr_ptr to sel + 1, go to IDLE.
REQ-030 Macro undefined: no watchdog logic; REQ waits indefinitely; err tied to 0.

Verification
REQ-031 Reset then ch_req = 2'b01, ch_dir = 1, write_ack after 5 cycles -> write_req with sdram_addr = 0x00000; ch_done = 01; next burst address = 0x00100.
REQ-032 ch_req = 2'b11 held, acks after 3 cycles -> grants alternate ch0, ch1, ch0; ch1 addresses = 0x40000, 0x40100.
REQ-033 ch0 offset at 0x3FF00, one more burst acked -> sdram_addr = 0x3FF00, then offset wraps to 0x00000.
REQ-034 ch_clr[0] on the DONE cycle of ch0 -> offset[0] = 0; next ch0 address = 0x00000.
REQ-035 ch0 read pending, write_ack pulsed -> ignored; read_req stays high until read_ack.
REQ-036 SDRAM_ARB_TIMEOUT_EN defined, TIMEOUT_CYC = 16, no ack -> err pulses once after 16 REQ cycles; no ch_done; offset unchanged; ch1 served next.

Source files
------------

// File: rtl/sdram_rr_arb_if.sv
// Channel-side and SDRAM-side handshake bundle for the round-robin SDRAM arbiter.
// The arbiter takes the master modport; the channel/SDRAM environment takes slave.
interface sdram_rr_arb_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 20
);
  logic [NUM_CH-1:0] ch_req;
  logic [NUM_CH-1:0] ch_dir;
  logic [NUM_CH-1:0] ch_clr;
  logic [NUM_CH-1:0] ch_done;
  logic [ADDR_W-1:0] sdram_addr;
  logic              write_req;
  logic              read_req;
  logic              write_ack;
  logic              read_ack;
  logic              err;

  modport master (
    input  ch_req, ch_dir, ch_clr, write_ack, read_ack,
    output ch_done, sdram_addr, write_req, read_req, err
  );

  modport slave (
    output ch_req, ch_dir, ch_clr, write_ack, read_ack,
    input  ch_done, sdram_addr, write_req, read_req, err
  );
endinterface

// File: rtl/sdram_rr_arb.sv
// Round-robin burst arbiter: NUM_CH channels share one SDRAM burst port, each with its own
// address region and running offset. Optional watchdog enabled by macro SDRAM_ARB_TIMEOUT_EN.
module sdram_rr_arb #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 20,
  parameter int REGION_W    = 18,
  parameter int BURST_LEN   = 256,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic            S_CLK,
  input  logic            RST_N,
  sdram_rr_arb_if.master  bus
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (REGION_W + $clog2(NUM_CH) > ADDR_W) begin : g_bad_region
    $error("sdram_rr_arb: channel regions do not fit in ADDR_W");
  end
  if (BURST_LEN < 1 || (BURST_LEN & (BURST_LEN - 1)) != 0 || BURST_LEN >= (1 << REGION_W)) begin : g_bad_burst
    $error("sdram_rr_arb: BURST_LEN must be a power of two below 2**REGION_W");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("sdram_rr_arb: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    rr_q, rr_d;
  logic                dir_q, dir_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [REGION_W-1:0] offset_q [NUM_CH];

  logic                found;
  logic [SEL_W-1:0]    win;
  logic [SEL_W-1:0]    sel_next;
  logic                ack_match;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            timeout;
  assign timeout = (wd_q == WD_W'(TIMEOUT_CYC - 1));
`endif

  // Winner search starts at rr_ptr and wraps modulo NUM_CH.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % NUM_CH;
      if (!found && bus.ch_req[SEL_W'(idx)]) begin
        found = 1'b1;
        win   = SEL_W'(idx);
      end
    end
  end

  assign sel_next  = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
  assign ack_match = dir_q ? bus.write_ack : bus.read_ack;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    done_d  = '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    wd_d    = '0;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = win;
          dir_d   = bus.ch_dir[win];
          addr_d  = (ADDR_W'(win) << REGION_W) + ADDR_W'(offset_q[win]);
          wr_d    = bus.ch_dir[win];
          rd_d    = ~bus.ch_dir[win];
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_match) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          done_d  = NUM_CH'(1) << sel_q;
          state_d = DONE;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (timeout) begin
          // Abort: drop the burst, keep the offset, and let the next channel in.
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          err_d   = 1'b1;
          rr_d    = sel_next;
          state_d = IDLE;
        end else begin
          wd_d    = wd_q + 1'b1;
        end
`endif
      end
      DONE: begin
        rr_d    = sel_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  // Offsets advance while in DONE; a same-cycle clear takes priority.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_CH; i++) offset_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.ch_clr[i])
          offset_q[i] <= '0;
        else if (state_q == DONE && sel_q == SEL_W'(i))
          offset_q[i] <= offset_q[i] + REGION_W'(BURST_LEN);
      end
    end
  end

  assign bus.write_req  = wr_q;
  assign bus.read_req   = rd_q;
  assign bus.sdram_addr = addr_q;
  assign bus.ch_done    = done_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_rr_arb.sv
// Directed bench for sdram_rr_arb (2 channels, 20-bit address, 18-bit regions, 256-word bursts).
module tb_sdram_rr_arb;

  logic S_CLK;
  logic RST_N;
  int   checks;
  int   failures;

  sdram_rr_arb_if #(.NUM_CH(2), .ADDR_W(20)) bus ();

  sdram_rr_arb #(
    .NUM_CH(2), .ADDR_W(20), .REGION_W(18), .BURST_LEN(256), .TIMEOUT_CYC(16)
  ) dut (
    .S_CLK (S_CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial S_CLK = 1'b0;
  always #5 S_CLK = ~S_CLK;

  task automatic tick();
    @(posedge S_CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    bus.ch_req = '0; bus.ch_dir = '0; bus.ch_clr = '0;
    bus.write_ack = 1'b0; bus.read_ack = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic wait_grant(output bit ok);
    int n;
    n = 0;
    while (!(bus.write_req || bus.read_req) && n < 20) begin tick(); n++; end
    ok = bus.write_req || bus.read_req;
  endtask

  // Serves one burst: waits for the grant, acks after dly cycles, returns to IDLE.
  task automatic serve(input int dly, output logic [19:0] a, output logic wr,
                       output logic [1:0] dn, output bit ok, output bit stable,
                       output bit idle_gap);
    stable = 1'b1; idle_gap = 1'b0; a = '0; wr = 1'b0; dn = '0;
    wait_grant(ok);
    if (!ok) return;
    a  = bus.sdram_addr;
    wr = bus.write_req;
    repeat (dly) begin
      tick();
      if (bus.sdram_addr !== a || bus.write_req !== wr || bus.read_req !== ~wr) stable = 1'b0;
    end
    if (wr) bus.write_ack = 1'b1; else bus.read_ack = 1'b1;
    tick();
    dn = bus.ch_done;
    if (bus.write_req || bus.read_req) stable = 1'b0;
    bus.write_ack = 1'b0; bus.read_ack = 1'b0;
    tick();
    idle_gap = !(bus.write_req || bus.read_req) && (bus.ch_done == 2'b00);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    bus.ch_req = '0; bus.ch_dir = '0; bus.ch_clr = '0;
    bus.write_ack = 1'b0; bus.read_ack = 1'b0;
    #1;
    checks++; if (bus.write_req !== 1'b0) begin failures++; $display("FAIL reset_write_req got=%b want=0", bus.write_req); end
    checks++; if (bus.read_req !== 1'b0) begin failures++; $display("FAIL reset_read_req got=%b want=0", bus.read_req); end
    checks++; if (bus.ch_done !== 2'b00) begin failures++; $display("FAIL reset_ch_done got=%b want=00", bus.ch_done); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus.err); end
    checks++; if (bus.sdram_addr !== 20'h00000) begin failures++; $display("FAIL reset_addr got=%h want=00000", bus.sdram_addr); end
    tick(); RST_N = 1'b1; tick(); tick();
    checks++; if ((bus.write_req | bus.read_req) !== 1'b0) begin failures++; $display("FAIL idle_no_req got=%b want=0", bus.write_req | bus.read_req); end
  endtask

  task automatic test_single_write();
    logic [19:0] a; logic wr; logic [1:0] dn; bit ok, st, ig;
    do_reset();
    bus.ch_dir = 2'b01; bus.ch_req = 2'b01;
    tick();
    checks++; if (bus.write_req !== 1'b1) begin failures++; $display("FAIL latency_write_req got=%b want=1", bus.write_req); end
    bus.ch_req = 2'b00;
    serve(5, a, wr, dn, ok, st, ig);
    checks++; if (!ok || a !== 20'h00000 || wr !== 1'b1) begin failures++; $display("FAIL single_first ok=%0d addr=%h wr=%b want addr=00000 wr=1", ok, a, wr); end
    checks++; if (!st) begin failures++; $display("FAIL single_stable got=0 want=1"); end
    checks++; if (dn !== 2'b01) begin failures++; $display("FAIL single_done got=%b want=01", dn); end
    bus.ch_req = 2'b01;
    serve(0, a, wr, dn, ok, st, ig);
    bus.ch_req = 2'b00;
    checks++; if (!ok || a !== 20'h00100) begin failures++; $display("FAIL single_second ok=%0d addr=%h want=00100", ok, a); end
  endtask

  task automatic test_alternate();
    logic [19:0] a; logic wr; logic [1:0] dn; bit ok, st, ig;
    logic [19:0] exp_a [4];
    logic [1:0]  exp_d [4];
    exp_a[0] = 20'h00000; exp_a[1] = 20'h40000; exp_a[2] = 20'h00100; exp_a[3] = 20'h40100;
    exp_d[0] = 2'b01; exp_d[1] = 2'b10; exp_d[2] = 2'b01; exp_d[3] = 2'b10;
    do_reset();
    bus.ch_dir = 2'b00; bus.ch_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serve(3, a, wr, dn, ok, st, ig);
      checks++; if (!ok || a !== exp_a[i] || wr !== 1'b0) begin failures++; $display("FAIL alt_addr[%0d] ok=%0d addr=%h wr=%b want addr=%h wr=0", i, ok, a, wr, exp_a[i]); end
      checks++; if (dn !== exp_d[i]) begin failures++; $display("FAIL alt_done[%0d] got=%b want=%b", i, dn, exp_d[i]); end
      checks++; if (!ig || !st) begin failures++; $display("FAIL alt_gap[%0d] idle_gap=%0d stable=%0d want 1 1", i, ig, st); end
    end
    bus.ch_req = 2'b00;
  endtask

  task automatic test_wrap();
    logic [19:0] a; logic wr; logic [1:0] dn; bit ok, st, ig;
    logic [19:0] exp;
    do_reset();
    bus.ch_dir = 2'b01; bus.ch_req = 2'b01;
    exp = 20'h00000;
    for (int k = 0; k < 1025; k++) begin
      serve(0, a, wr, dn, ok, st, ig);
      checks++; if (!ok || a !== exp) begin failures++; $display("FAIL wrap_addr[%0d] ok=%0d addr=%h want=%h", k, ok, a, exp); end
      exp = (exp == 20'h3FF00) ? 20'h00000 : exp + 20'h00100;
    end
    bus.ch_req = 2'b00;
  endtask

  task automatic test_clear();
    logic [19:0] a; logic wr; logic [1:0] dn; bit ok, st, ig;
    do_reset();
    bus.ch_dir = 2'b01; bus.ch_req = 2'b01;
    serve(0, a, wr, dn, ok, st, ig);
    wait_grant(ok);
    checks++; if (!ok || bus.sdram_addr !== 20'h00100) begin failures++; $display("FAIL clr_pre_addr ok=%0d addr=%h want=00100", ok, bus.sdram_addr); end
    bus.ch_clr = 2'b01; tick(); bus.ch_clr = 2'b00; tick();
    checks++; if (bus.sdram_addr !== 20'h00100 || bus.write_req !== 1'b1) begin failures++; $display("FAIL clr_in_req addr=%h wr=%b want 00100 1", bus.sdram_addr, bus.write_req); end
    bus.write_ack = 1'b1; tick(); bus.write_ack = 1'b0;
    checks++; if (bus.ch_done !== 2'b01) begin failures++; $display("FAIL clr_done got=%b want=01", bus.ch_done); end
    bus.ch_clr = 2'b01; tick(); bus.ch_clr = 2'b00;
    serve(0, a, wr, dn, ok, st, ig);
    bus.ch_req = 2'b00;
    checks++; if (!ok || a !== 20'h00000) begin failures++; $display("FAIL clr_on_done_addr ok=%0d addr=%h want=00000", ok, a); end
  endtask

  task automatic test_ack_mismatch();
    bit ok;
    do_reset();
    bus.ch_dir = 2'b00; bus.ch_req = 2'b01;
    wait_grant(ok);
    bus.ch_req = 2'b00;
    checks++; if (!ok || bus.read_req !== 1'b1 || bus.write_req !== 1'b0) begin failures++; $display("FAIL mis_grant rd=%b wr=%b want 1 0", bus.read_req, bus.write_req); end
    bus.write_ack = 1'b1; tick(); bus.write_ack = 1'b0;
    tick(); tick();
    checks++; if (bus.read_req !== 1'b1 || bus.ch_done !== 2'b00) begin failures++; $display("FAIL mis_ignored rd=%b done=%b want 1 00", bus.read_req, bus.ch_done); end
    bus.read_ack = 1'b1; tick(); bus.read_ack = 1'b0;
    checks++; if (bus.read_req !== 1'b0 || bus.ch_done !== 2'b01) begin failures++; $display("FAIL mis_acked rd=%b done=%b want 0 01", bus.read_req, bus.ch_done); end
    tick();
    checks++; if (bus.ch_done !== 2'b00) begin failures++; $display("FAIL mis_done_pulse got=%b want=00", bus.ch_done); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    logic [1:0] seen;
    do_reset();
    bus.ch_dir = 2'b00; bus.ch_req = 2'b01;
    wait_grant(ok);
    #2 RST_N = 1'b0;
    #1;
    checks++; if (!ok || bus.read_req !== 1'b0 || bus.sdram_addr !== 20'h00000) begin failures++; $display("FAIL mid_reset ok=%0d rd=%b addr=%h want 0 00000", ok, bus.read_req, bus.sdram_addr); end
    bus.ch_req = 2'b00;
    tick(); RST_N = 1'b1;
    bus.read_ack = 1'b1; tick(); bus.read_ack = 1'b0;
    seen = bus.ch_done;
    repeat (4) begin tick(); seen |= bus.ch_done; end
    checks++; if (seen !== 2'b00 || bus.read_req !== 1'b0) begin failures++; $display("FAIL mid_no_done done=%b rd=%b want 00 0", seen, bus.read_req); end
  endtask

  task automatic test_watchdog();
    logic [19:0] a; logic wr; logic [1:0] dn; bit ok, st, ig;
`ifdef SDRAM_ARB_TIMEOUT_EN
    int n;
    do_reset();
    bus.ch_dir = 2'b11; bus.ch_req = 2'b11;
    wait_grant(ok);
    n = 0;
    while (bus.write_req && n < 40) begin tick(); n++; end
    checks++; if (!ok || n != 16) begin failures++; $display("FAIL wd_cycles got=%0d want=16", n); end
    checks++; if (bus.err !== 1'b1 || bus.ch_done !== 2'b00) begin failures++; $display("FAIL wd_err err=%b done=%b want 1 00", bus.err, bus.ch_done); end
    tick();
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL wd_err_pulse got=%b want=0", bus.err); end
    serve(0, a, wr, dn, ok, st, ig);
    checks++; if (!ok || a !== 20'h40000 || dn !== 2'b10) begin failures++; $display("FAIL wd_next_ch addr=%h done=%b want 40000 10", a, dn); end
    serve(0, a, wr, dn, ok, st, ig);
    checks++; if (!ok || a !== 20'h00000) begin failures++; $display("FAIL wd_offset_kept addr=%h want=00000", a); end
    bus.ch_req = 2'b00;
`else
    logic err_seen;
    do_reset();
    bus.ch_dir = 2'b01; bus.ch_req = 2'b01;
    wait_grant(ok);
    bus.ch_req = 2'b00;
    err_seen = 1'b0;
    repeat (30) begin tick(); err_seen |= bus.err; end
    checks++; if (!ok || bus.write_req !== 1'b1 || err_seen !== 1'b0) begin failures++; $display("FAIL nowd_wait wr=%b err=%b want 1 0", bus.write_req, err_seen); end
    bus.write_ack = 1'b1; tick(); bus.write_ack = 1'b0;
    checks++; if (bus.ch_done !== 2'b01) begin failures++; $display("FAIL nowd_done got=%b want=01", bus.ch_done); end
    a = '0; wr = 1'b0; dn = '0; st = 1'b0; ig = 1'b0;
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_write();
    test_alternate();
    test_wrap();
    test_clear();
    test_ack_mismatch();
    test_reset_mid_burst();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached without completing the test sequence");
    $fatal(1, "timeout");
  end

endmodule
